// File: rtl/screen_pkg.sv
// Shared geometry defaults, terminal control codes and FSM encoding for the screen buffer.
package screen_pkg;

    localparam int DEF_COLS = 16;
    localparam int DEF_ROWS = 4;

    localparam logic [7:0] ASCII_BS    = 8'h08;
    localparam logic [7:0] ASCII_LF    = 8'h0A;
    localparam logic [7:0] ASCII_FF    = 8'h0C;
    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_SPACE = 8'h20;
    localparam logic [7:0] ASCII_TILDE = 8'h7E;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_t;

endpackage

// File: rtl/screen_char_ram.sv
// Character store: one write port, registered read port (1-cycle latency, read-before-write).
// No backpressure; the caller guarantees at most one write per cycle.
module screen_char_ram #(
    parameter int DEPTH = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] wrAddr,
    input  logic [7:0]    wrData,
    input  logic [AW-1:0] rdAddr,
    output logic [7:0]    rdData
);

    logic [7:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[wrAddr] <= wrData;
        end
    end

    // Only the output register is reset; the array itself is cleared by the arbiter's sweep.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdData <= 8'h00;
        end else begin
            rdData <= mem[rdAddr];
        end
    end

endmodule

// File: rtl/screen_write_arbiter.sv
// Screen buffer owner: CPU > clear sweep > UART terminal stream on one write port; reads 1-cycle latency.
// CPU writes are never stalled; the UART is held off (uart_ready low) during clears and CPU write cycles.
module screen_write_arbiter
    import screen_pkg::*;
#(
    parameter int          COLS      = DEF_COLS,
    parameter int          ROWS      = DEF_ROWS,
    parameter logic [7:0]  FILL_CHAR = ASCII_SPACE,
    localparam int         DEPTH     = COLS * ROWS,
    localparam int         AW        = $clog2(DEPTH),
    localparam int         CW        = $clog2(COLS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_index,
    input  logic [7:0]    cpu_char,
    input  logic          uart_valid,
    input  logic [7:0]    uart_byte,
    output logic          uart_ready,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_char,
    output logic          clr_busy,
    output logic [AW-1:0] cursor
);

    state_t        state, nextState;
    logic [AW-1:0] clrPtr, nextPtr;
    logic [AW-1:0] nextCursor;
    logic          ramWe;
    logic [AW-1:0] ramAddr;
    logic [7:0]    ramData;

    assign uart_ready = (state == ST_IDLE) && !cpu_we;
    assign clr_busy   = (state == ST_CLEAR);

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_CLEAR;
            clrPtr <= '0;
            cursor <= '0;
        end else begin
            state  <= nextState;
            clrPtr <= nextPtr;
            cursor <= nextCursor;
        end
    end

    always_comb begin
        nextState  = state;
        nextPtr    = clrPtr;
        nextCursor = cursor;
        ramWe      = 1'b0;
        ramAddr    = '0;
        ramData    = 8'h00;

        if (cpu_we) begin
            // CPU steals the port; during a clear the sweep pointer simply holds.
            ramWe   = 1'b1;
            ramAddr = cpu_index;
            ramData = cpu_char;
        end else if (state == ST_CLEAR) begin
            ramWe   = 1'b1;
            ramAddr = clrPtr;
            ramData = FILL_CHAR;
            if (clrPtr == AW'(DEPTH - 1)) begin
                nextState = ST_IDLE;
                nextPtr   = '0;
            end else begin
                nextPtr = clrPtr + 1'b1;
            end
        end else if (uart_valid) begin
            if (uart_byte >= ASCII_SPACE && uart_byte <= ASCII_TILDE) begin
                ramWe      = 1'b1;
                ramAddr    = cursor;
                ramData    = uart_byte;
                nextCursor = cursor + 1'b1;
            end else begin
                case (uart_byte)
                    ASCII_CR: nextCursor = {cursor[AW-1:CW], {CW{1'b0}}};
                    ASCII_LF: nextCursor = cursor + AW'(COLS);
                    ASCII_BS: begin
                        if (cursor[CW-1:0] != '0) begin
                            nextCursor = cursor - 1'b1;
                        end
                    end
                    ASCII_FF: begin
                        nextCursor = '0;
                        nextPtr    = '0;
                        nextState  = ST_CLEAR;
                    end
                    default: ;
                endcase
            end
        end
    end

    screen_char_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk    (clk),
        .rst    (rst),
        .we     (ramWe && !rst),
        .wrAddr (ramAddr),
        .wrData (ramData),
        .rdAddr (rd_addr),
        .rdData (rd_char)
    );

endmodule

// File: tb/tb_screen_write_arbiter.sv
// Directed-vector bench for screen_write_arbiter: reset clear, UART terminal codes, CPU priority, FF/rst clears.
module tb_screen_write_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       cpu_we = 1'b0;
    logic [5:0] cpu_index = '0;
    logic [7:0] cpu_char = '0;
    logic       uart_valid = 1'b0;
    logic [7:0] uart_byte = '0;
    logic       uart_ready;
    logic [5:0] rd_addr = '0;
    logic [7:0] rd_char;
    logic       clr_busy;
    logic [5:0] cursor;

    int checks = 0;
    int errors = 0;

    screen_write_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .cpu_we     (cpu_we),
        .cpu_index  (cpu_index),
        .cpu_char   (cpu_char),
        .uart_valid (uart_valid),
        .uart_byte  (uart_byte),
        .uart_ready (uart_ready),
        .rd_addr    (rd_addr),
        .rd_char    (rd_char),
        .clr_busy   (clr_busy),
        .cursor     (cursor)
    );

    always #5 clk = ~clk;

    // Stimulus helpers (no comparisons apart from the handshake timeout).
    task automatic send_byte(input logic [7:0] b);
        int n;
        @(negedge clk);
        uart_valid = 1'b1;
        uart_byte  = b;
        n = 0;
        while (!uart_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) begin
            errors++;
            $display("FAIL uart_handshake_timeout byte=%h waited=%0d cycles required<300", b, n);
        end
        @(negedge clk);
        uart_valid = 1'b0;
    endtask

    task automatic read_char(input logic [5:0] a, output logic [7:0] d);
        @(negedge clk);
        rd_addr = a;
        @(negedge clk);
        d = rd_char;
    endtask

    task automatic test_reset;
        int n;
        logic [7:0] d;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++; if (rd_char !== 8'h00) begin errors++; $display("FAIL reset_rd_char got=%h exp=00", rd_char); end
        checks++; if (clr_busy !== 1'b1) begin errors++; $display("FAIL reset_clr_busy got=%b exp=1", clr_busy); end
        checks++; if (uart_ready !== 1'b0) begin errors++; $display("FAIL reset_uart_ready got=%b exp=0", uart_ready); end
        checks++; if (cursor !== 6'd0) begin errors++; $display("FAIL reset_cursor got=%0d exp=0", cursor); end
        rst = 1'b0;
        n = 0;
        while (clr_busy === 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++; if (n !== 64) begin errors++; $display("FAIL reset_clear_cycles got=%0d exp=64", n); end
        for (int a = 0; a < 64; a++) begin
            read_char(6'(a), d);
            checks++; if (d !== 8'h20) begin errors++; $display("FAIL reset_fill addr=%0d got=%h exp=20", a, d); end
        end
    endtask

    task automatic test_uart_text;
        logic [7:0] d;
        send_byte(8'h48);
        send_byte(8'h49);
        checks++; if (cursor !== 6'd2) begin errors++; $display("FAIL text_cursor got=%0d exp=2", cursor); end
        read_char(6'd0, d);
        checks++; if (d !== 8'h48) begin errors++; $display("FAIL text_buf0 got=%h exp=48", d); end
        read_char(6'd1, d);
        checks++; if (d !== 8'h49) begin errors++; $display("FAIL text_buf1 got=%h exp=49", d); end
        read_char(6'd2, d);
        checks++; if (d !== 8'h20) begin errors++; $display("FAIL text_buf2 got=%h exp=20", d); end
    endtask

    task automatic test_cursor_codes;
        logic [7:0] d;
        send_byte(8'h61); send_byte(8'h62); send_byte(8'h63);
        checks++; if (cursor !== 6'd5) begin errors++; $display("FAIL codes_cursor5 got=%0d exp=5", cursor); end
        send_byte(8'h0D);
        checks++; if (cursor !== 6'd0) begin errors++; $display("FAIL codes_cr got=%0d exp=0", cursor); end
        send_byte(8'h0A);
        checks++; if (cursor !== 6'd16) begin errors++; $display("FAIL codes_lf got=%0d exp=16", cursor); end
        read_char(6'd16, d);
        checks++; if (d !== 8'h20) begin errors++; $display("FAIL codes_no_write got=%h exp=20", d); end
        send_byte(8'h0A); send_byte(8'h0A);
        for (int i = 0; i < 15; i++) send_byte(8'h2E);
        checks++; if (cursor !== 6'd63) begin errors++; $display("FAIL codes_cursor63 got=%0d exp=63", cursor); end
        send_byte(8'h41);
        checks++; if (cursor !== 6'd0) begin errors++; $display("FAIL codes_wrap got=%0d exp=0", cursor); end
        read_char(6'd63, d);
        checks++; if (d !== 8'h41) begin errors++; $display("FAIL codes_buf63 got=%h exp=41", d); end
        read_char(6'd62, d);
        checks++; if (d !== 8'h2E) begin errors++; $display("FAIL codes_buf62 got=%h exp=2E", d); end
    endtask

    task automatic test_cpu_priority;
        logic [7:0] d;
        @(negedge clk);
        cpu_we = 1'b1; cpu_index = 6'd7; cpu_char = 8'h5A;
        uart_valid = 1'b1; uart_byte = 8'h42;
        #1;
        checks++; if (uart_ready !== 1'b0) begin errors++; $display("FAIL prio_ready_blocked got=%b exp=0", uart_ready); end
        @(negedge clk);
        cpu_we = 1'b0;
        #1;
        checks++; if (uart_ready !== 1'b1) begin errors++; $display("FAIL prio_ready_next got=%b exp=1", uart_ready); end
        checks++; if (cursor !== 6'd0) begin errors++; $display("FAIL prio_cursor_held got=%0d exp=0", cursor); end
        @(negedge clk);
        uart_valid = 1'b0;
        checks++; if (cursor !== 6'd1) begin errors++; $display("FAIL prio_cursor got=%0d exp=1", cursor); end
        read_char(6'd7, d);
        checks++; if (d !== 8'h5A) begin errors++; $display("FAIL prio_buf7 got=%h exp=5A", d); end
        read_char(6'd0, d);
        checks++; if (d !== 8'h42) begin errors++; $display("FAIL prio_buf0 got=%h exp=42", d); end
        send_byte(8'h01);
        send_byte(8'h7F);
        checks++; if (cursor !== 6'd1) begin errors++; $display("FAIL other_bytes_cursor got=%0d exp=1", cursor); end
        read_char(6'd1, d);
        checks++; if (d !== 8'h49) begin errors++; $display("FAIL other_bytes_buf1 got=%h exp=49", d); end
    endtask

    task automatic test_form_feed;
        int busy;
        logic [7:0] d;
        send_byte(8'h0C);
        checks++; if (uart_ready !== 1'b0) begin errors++; $display("FAIL ff_ready_low got=%b exp=0", uart_ready); end
        checks++; if (cursor !== 6'd0) begin errors++; $display("FAIL ff_cursor got=%0d exp=0", cursor); end
        busy = 0;
        for (int i = 0; i < 200; i++) begin
            if (clr_busy !== 1'b1) break;
            busy++;
            if (busy == 11) begin
                cpu_we = 1'b1; cpu_index = 6'd3; cpu_char = 8'h5A;
            end else begin
                cpu_we = 1'b0;
            end
            @(negedge clk);
        end
        cpu_we = 1'b0;
        checks++; if (busy !== 65) begin errors++; $display("FAIL ff_busy_cycles got=%0d exp=65", busy); end
        for (int a = 0; a < 64; a++) begin
            read_char(6'(a), d);
            checks++;
            if (a == 3) begin
                if (d !== 8'h5A) begin errors++; $display("FAIL ff_cpu_survives addr=3 got=%h exp=5A", d); end
            end else if (d !== 8'h20) begin
                errors++; $display("FAIL ff_fill addr=%0d got=%h exp=20", a, d);
            end
        end
    endtask

    task automatic test_reset_mid_clear;
        int n;
        logic [7:0] d;
        send_byte(8'h0C);
        repeat (30) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++; if (cursor !== 6'd0) begin errors++; $display("FAIL rstmid_cursor got=%0d exp=0", cursor); end
        n = 0;
        while (clr_busy === 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++; if (n !== 64) begin errors++; $display("FAIL rstmid_busy_cycles got=%0d exp=64", n); end
        send_byte(8'h0A);
        checks++; if (cursor !== 6'd16) begin errors++; $display("FAIL bs_setup got=%0d exp=16", cursor); end
        send_byte(8'h08);
        checks++; if (cursor !== 6'd16) begin errors++; $display("FAIL bs_col0 got=%0d exp=16", cursor); end
        read_char(6'd15, d);
        checks++; if (d !== 8'h20) begin errors++; $display("FAIL bs_no_write15 got=%h exp=20", d); end
        read_char(6'd16, d);
        checks++; if (d !== 8'h20) begin errors++; $display("FAIL bs_no_write16 got=%h exp=20", d); end
        send_byte(8'h78);
        send_byte(8'h08);
        checks++; if (cursor !== 6'd16) begin errors++; $display("FAIL bs_step_back got=%0d exp=16", cursor); end
        read_char(6'd16, d);
        checks++; if (d !== 8'h78) begin errors++; $display("FAIL bs_keeps_char got=%h exp=78", d); end
    endtask

    initial begin
        test_reset();
        test_uart_text();
        test_cursor_codes();
        test_cpu_priority();
        test_form_feed();
        test_reset_mid_clear();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
